// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared state encoding, parameter defaults and ratio legality check
package clkdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam int MAX_DIV_DEFAULT = 16;
  localparam int DEF_DIV_DEFAULT = 2;

  function automatic logic ratio_legal(input logic [31:0] div, input logic [31:0] max_div);
    return (div[0] == 1'b0) && (div >= 32'd2) && (div <= max_div);
  endfunction

endpackage

// File: rtl/clkdiv_core.sv
// rtl/clkdiv_core.sv - half-period counter and output toggle for the divided clock
module clkdiv_core #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] ratio,
  input  logic         run,
  input  logic         load,
  output logic         div_out,
  output logic         boundary
);

  logic [W-1:0] cnt;
  logic         terminal;

  assign terminal = (cnt == ((ratio >> 1) - W'(1)));
  // Raw boundary; the controller decides whether it is meaningful in the current state.
  assign boundary = terminal & ~div_out;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt     <= '0;
      div_out <= 1'b0;
    end else if (load) begin
      cnt     <= '0;
      div_out <= 1'b1;
    end else if (run) begin
      if (terminal) begin
        cnt     <= '0;
        div_out <= ~div_out;
      end else begin
        cnt <= cnt + W'(1);
      end
    end else begin
      cnt     <= '0;
      div_out <= 1'b0;
    end
  end

endmodule

// File: rtl/clkdiv_ratio_ctrl.sv
// rtl/clkdiv_ratio_ctrl.sv - divided clock generator with glitch-free ratio change handshake
module clkdiv_ratio_ctrl
  import clkdiv_pkg::*;
#(
  parameter int MAX_DIV = MAX_DIV_DEFAULT,
  parameter int DEF_DIV = DEF_DIV_DEFAULT,
  localparam int W = $clog2(MAX_DIV) + 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clk_en,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic         div_out,
  output logic         period_start,
  output logic [W-1:0] div_active
);

  state_t       state;
  logic [W-1:0] pend_div;
  logic         legal;
  logic         xfer;
  logic         active;
  logic         start;
  logic         stop;
  logic         run;
  logic         boundary;

  assign legal     = ratio_legal(32'(cfg_div), 32'(MAX_DIV));
  assign cfg_ready = (state != PEND);
  assign xfer      = cfg_valid & cfg_ready;
  assign active    = (state != IDLE);
  assign start     = (state == IDLE) & clk_en;
  // Stopping only at a boundary lets the last period finish its low phase.
  assign stop      = active & boundary & ~clk_en;
  assign run       = active & ~stop;

  clkdiv_core #(.W(W)) u_core (
    .clk      (clk),
    .resetn   (resetn),
    .ratio    (div_active),
    .run      (run),
    .load     (start),
    .div_out  (div_out),
    .boundary (boundary)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      div_active   <= W'(DEF_DIV);
      pend_div     <= W'(DEF_DIV);
      cfg_err      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      cfg_err      <= xfer & ~legal;
      period_start <= start | (active & boundary & clk_en);
      case (state)
        IDLE: begin
          if (xfer && legal) div_active <= cfg_div;
          if (clk_en) state <= RUN;
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            if (xfer && legal) div_active <= cfg_div;
          end else if (xfer && legal) begin
            pend_div <= cfg_div;
            state    <= PEND;
          end
        end
        PEND: begin
          // New ratio lands on the same edge the counter clears, so the next period uses it whole.
          if (boundary) begin
            div_active <= pend_div;
            state      <= clk_en ? RUN : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clkdiv_ratio_ctrl.sv
// tb/tb_clkdiv_ratio_ctrl.sv - directed self-checking bench for clkdiv_ratio_ctrl
module tb_clkdiv_ratio_ctrl;
  import clkdiv_pkg::*;

  localparam int W = $clog2(16) + 1;

  logic         clk = 1'b0;
  logic         resetn;
  logic         clk_en;
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         cfg_err;
  logic         div_out;
  logic         period_start;
  logic [W-1:0] div_active;

  int checks = 0;
  int errors = 0;

  clkdiv_ratio_ctrl #(.MAX_DIV(16), .DEF_DIV(2)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .clk_en       (clk_en),
    .cfg_valid    (cfg_valid),
    .cfg_div      (cfg_div),
    .cfg_ready    (cfg_ready),
    .cfg_err      (cfg_err),
    .div_out      (div_out),
    .period_start (period_start),
    .div_active   (div_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] bad_divs [3];

  initial begin
    bad_divs[0] = 5'd5;
    bad_divs[1] = 5'd0;
    bad_divs[2] = 5'd18;
    resetn    = 1'b0;
    clk_en    = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    tick();
    tick();
    check("rst_div_out", 32'(div_out), 0);
    check("rst_period_start", 32'(period_start), 0);
    check("rst_cfg_err", 32'(cfg_err), 0);
    check("rst_cfg_ready", 32'(cfg_ready), 1);
    check("rst_div_active", 32'(div_active), 2);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    resetn = 1'b1;
    tick();
    tick();
    check("idle_hold", 32'(div_out), 0);

    // ratio 2: toggles every cycle
    clk_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("r2_div_out", 32'(div_out), (i % 2 == 0) ? 1 : 0);
      check("r2_pstart", 32'(period_start), (i % 2 == 0) ? 1 : 0);
    end
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("r2_stopped", 32'(div_out), 0);
    end
    check("r2_idle", 32'(dut.state), 32'(IDLE));

    // illegal ratios
    for (int k = 0; k < 3; k++) begin
      cfg_valid = 1'b1;
      cfg_div   = bad_divs[k];
      tick();
      cfg_valid = 1'b0;
      check("bad_err_pulse", 32'(cfg_err), 1);
      check("bad_div_active", 32'(div_active), 2);
      check("bad_state", 32'(dut.state), 32'(IDLE));
      tick();
      check("bad_err_clear", 32'(cfg_err), 0);
    end

    // ratio 4 transfer coincident with start
    cfg_valid = 1'b1;
    cfg_div   = 5'd4;
    clk_en    = 1'b1;
    tick();
    cfg_valid = 1'b0;
    check("st4_div_active", 32'(div_active), 4);
    check("st4_cfg_err", 32'(cfg_err), 0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      check("st4_div_out", 32'(div_out), ((i % 4) < 2) ? 1 : 0);
      check("st4_pstart", 32'(period_start), ((i % 4) == 0) ? 1 : 0);
    end

    // change 4 -> 6 in the high phase
    tick();
    check("chg_pstart", 32'(period_start), 1);
    check("chg_ready_before", 32'(cfg_ready), 1);
    cfg_valid = 1'b1;
    cfg_div   = 5'd6;
    for (int j = 1; j < 16; j++) begin
      tick();
      if (j == 1) cfg_valid = 1'b0;
      if (j < 4) begin
        check("chg_old_div_out", 32'(div_out), (j < 2) ? 1 : 0);
        check("chg_old_pstart", 32'(period_start), 0);
        check("chg_ready_low", 32'(cfg_ready), 0);
      end else begin
        check("chg_new_div_out", 32'(div_out), (((j - 4) % 6) < 3) ? 1 : 0);
        check("chg_new_pstart", 32'(period_start), (((j - 4) % 6) == 0) ? 1 : 0);
        check("chg_ready_high", 32'(cfg_ready), 1);
      end
      if (j == 4) check("chg_div_active", 32'(div_active), 6);
    end

    // transfer at a boundary enters PEND, then async reset mid-period
    cfg_valid = 1'b1;
    cfg_div   = 5'd8;
    tick();
    cfg_valid = 1'b0;
    check("pend_pstart", 32'(period_start), 1);
    check("pend_ready", 32'(cfg_ready), 0);
    check("pend_div_active", 32'(div_active), 6);
    tick();
    check("pend_high", 32'(div_out), 1);
    #2;
    resetn = 1'b0;
    clk_en = 1'b0;
    #1;
    check("arst_div_out", 32'(div_out), 0);
    check("arst_div_active", 32'(div_active), 2);
    check("arst_cfg_ready", 32'(cfg_ready), 1);
    tick();
    resetn = 1'b1;
    tick();
    tick();
    check("arst_no_start", 32'(div_out), 0);
    check("arst_pend_gone", 32'(div_active), 2);

    // ratio 8, clk_en dropped one cycle into the high phase
    cfg_valid = 1'b1;
    cfg_div   = 5'd8;
    tick();
    cfg_valid = 1'b0;
    check("r8_div_active", 32'(div_active), 8);
    clk_en = 1'b1;
    tick();
    check("r8_start", 32'(div_out), 1);
    check("r8_pstart", 32'(period_start), 1);
    clk_en = 1'b0;
    for (int j = 1; j < 13; j++) begin
      tick();
      check("r8_drain", 32'(div_out), (j < 4) ? 1 : 0);
      check("r8_no_pstart", 32'(period_start), 0);
    end
    check("r8_idle", 32'(dut.state), 32'(IDLE));
    check("r8_ready", 32'(cfg_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clkdiv_ratio_ctrl.md
CLKDIV_RATIO_CTRL -- requirements
Module: clkdiv_ratio_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_DIV, default 16: largest legal divide ratio; even, 2 or greater.
REQ-002 The block SHALL have parameter DEF_DIV, default 2: ratio loaded at reset; even, 2 to MAX_DIV.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port clk_en, input, 1 bit: run request for the divided output.
REQ-006 The block SHALL have port cfg_valid, input, 1 bit: a ratio change is offered.
REQ-007 The block SHALL have port cfg_div, input, W = $clog2(MAX_DIV)+1 bits: requested ratio.
REQ-008 The block SHALL have port cfg_ready, output, 1 bit: a ratio change can be accepted.
REQ-009 The block SHALL have port cfg_err, output, 1 bit: one-cycle pulse when an offered ratio is illegal.
REQ-010 The block SHALL have port div_out, output, 1 bit: registered divided clock.
REQ-011 The block SHALL have port period_start, output, 1 bit: one-cycle pulse coincident with each 0->1 transition of div_out.
REQ-012 The block SHALL have port div_active, output, W bits: ratio currently in effect.

Function
REQ-013 States SHALL be IDLE, RUN and PEND.
REQ-014 In RUN and PEND, the half-period counter cnt SHALL count 0 to div_active/2-1; at terminal count div_out SHALL toggle and cnt SHALL clear, giving period div_active with 50% duty.
REQ-015 A period boundary is the terminal count while div_out=0.
REQ-016 IDLE to RUN: when clk_en=1 is sampled in IDLE, div_out SHALL be 1 and period_start SHALL be 1 in the next cycle, with cnt=0.
REQ-017 At a period boundary in RUN or PEND with clk_en=0, the block SHALL go to IDLE and hold div_out=0; a period is never truncated.
REQ-018 A transfer SHALL occur when cfg_valid and cfg_ready are both 1; cfg_ready SHALL be 1 in IDLE and RUN and 0 in PEND.
REQ-019 A ratio is legal when it is even, 2 or greater, and no greater than MAX_DIV; an illegal transfer SHALL pulse cfg_err in the next cycle and change neither the state nor div_active.
REQ-020 A legal transfer in IDLE SHALL update div_active in the next cycle.
REQ-021 A legal transfer in RUN SHALL latch the ratio and enter PEND, including when the transfer coincides with a boundary.
REQ-022 At the next boundary, PEND SHALL load div_active from the latched ratio and return to RUN if clk_en=1, otherwise go to IDLE; the new period SHALL use the new ratio.
REQ-023 div_out SHALL never produce a high or low phase shorter than min(old, new)/2 cycles.
REQ-024 A transfer in the same cycle as the IDLE to RUN start SHALL apply its ratio to the first period.

Reset
REQ-025 While resetn=0, the block SHALL hold: state IDLE, div_out 0, period_start 0, cfg_err 0, cnt 0, div_active DEF_DIV, latched ratio DEF_DIV, and cfg_ready 1.
REQ-026 Reset assertion mid-period SHALL force div_out to 0 immediately and discard any pending ratio.
REQ-027 After reset deassertion, the block SHALL not start until clk_en is sampled as 1.

Structure
REQ-028 Package clkdiv_pkg SHALL hold the state enum (IDLE, RUN, PEND), MAX_DIV and DEF_DIV defaults, and a ratio-legality function.
REQ-029 The counter and toggle logic SHALL be the sub-module clkdiv_core, with inputs ratio, run and load and outputs div_out and boundary.
REQ-030 The FSM, handshake and legality check SHALL live in clkdiv_ratio_ctrl.

Verification
REQ-031 The bench SHALL cover: reset, clk_en=1, div_active=2 -> div_out toggles every cycle (period 2) and period_start fires every 2 cycles.
REQ-032 The bench SHALL cover: in RUN at ratio 4, offer ratio 6 mid-high-phase -> cfg_ready drops, the current period completes at 4 cycles, and the next periods are 6 cycles (3 high, 3 low).
REQ-033 The bench SHALL cover: offering cfg_div of 5, then 0, then 18 (MAX_DIV=16) -> cfg_err pulses once per offer and div_active is unchanged.
REQ-034 The bench SHALL cover: clk_en dropped 1 cycle into the high phase at ratio 8 -> 4 high and 4 low cycles complete, then div_out stays 0 and the state is IDLE.
REQ-035 The bench SHALL cover: resetn pulsed low mid-period while in PEND -> div_out becomes 0 asynchronously, div_active returns to 2, and cfg_ready is 1.
REQ-036 The bench SHALL cover: a transfer of ratio 4 in IDLE in the same cycle as clk_en rises -> the first period is 4 cycles.
